// File: rtl/csa_stream_accum_if.sv
// Valid/ready bundle for csa_stream_accum: operand beats in, resolved total out.
// The slave modport is the accumulator's view; the master modport is the producer/consumer view.
interface csa_stream_accum_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int OUT_W = 18
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_lane_en;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_sum;
  logic [15:0]            out_count;

  modport slave (
    input  in_valid, in_data, in_lane_en, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

  modport master (
    output in_valid, in_data, in_lane_en, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/csa_stream_accum.sv
// Streaming multi-operand adder: beats are folded into carry-save sum/carry registers and
// resolved by one carry-propagate add per transaction. Define CSA_SIGNED_EN for signed operands.
module csa_stream_accum #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int OUT_W = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  csa_stream_accum_if.slave   bus
);

  localparam int POP_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] ss_q, ss_d;
  logic [OUT_W-1:0] cc_q, cc_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      cntOut_q, cntOut_d;

  logic [OUT_W-1:0] csaS;
  logic [OUT_W-1:0] csaC;
  logic [OUT_W-1:0] operand;
  logic [OUT_W-1:0] stageSum;
  logic [POP_W-1:0] popCnt;
  logic [16:0]      countSum;
  logic [15:0]      countNext;
  logic             inReady;
  logic             outValid;

  function automatic logic [OUT_W-1:0] extendLane(input logic [WIDTH-1:0] v);
`ifdef CSA_SIGNED_EN
    return {{(OUT_W-WIDTH){v[WIDTH-1]}}, v};
`else
    return {{(OUT_W-WIDTH){1'b0}}, v};
`endif
  endfunction

  // Chain of 3:2 stages forms the (LANES+2):2 compressor; the carry bit leaving the top is dropped.
  always_comb begin
    csaS     = ss_q;
    csaC     = cc_q;
    operand  = '0;
    stageSum = '0;
    popCnt   = '0;
    for (int k = 0; k < LANES; k++) begin
      operand  = bus.in_lane_en[k] ? extendLane(bus.in_data[k*WIDTH +: WIDTH]) : '0;
      stageSum = csaS ^ csaC ^ operand;
      csaC     = ((csaS & csaC) | (csaS & operand) | (csaC & operand)) << 1;
      csaS     = stageSum;
      popCnt   = popCnt + POP_W'(bus.in_lane_en[k]);
    end
  end

  assign countSum  = {1'b0, count_q} + 17'(popCnt);
  assign countNext = countSum[16] ? 16'hFFFF : countSum[15:0];

  always_comb begin
    state_d  = state_q;
    ss_d     = ss_q;
    cc_d     = cc_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cntOut_d = cntOut_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    case (state_q)
      ACCUM: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          ss_d    = csaS;
          cc_d    = csaC;
          count_d = countNext;
          if (bus.in_last) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        sum_d    = ss_q + cc_q;
        cntOut_d = count_q;
        state_d  = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (bus.out_ready) begin
          ss_d    = '0;
          cc_d    = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      ss_q     <= '0;
      cc_q     <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      cntOut_q <= '0;
    end else begin
      state_q  <= state_d;
      ss_q     <= ss_d;
      cc_q     <= cc_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      cntOut_q <= cntOut_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_sum   = sum_q;
  assign bus.out_count = cntOut_q;

endmodule

// File: tb/tb_csa_stream_accum.sv
// Self-checking bench for csa_stream_accum: an integer-arithmetic scoreboard checked every
// cycle, plus literal expectations for each directed transaction. Honours CSA_SIGNED_EN.
module tb_csa_stream_accum;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int OUT_W = 18;

  logic clk = 1'b0;
  logic rst_n;

  csa_stream_accum_if #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W)) bus ();

  csa_stream_accum #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic             expReady;
  logic             expValid;
  logic [OUT_W-1:0] expSum;
  logic [15:0]      expCount;
  longint           modelAcc;
  longint           modelCnt;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  function automatic longint extendOp(input logic [WIDTH-1:0] v);
`ifdef CSA_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  // Scoreboard: handshake levels every cycle, result fields whenever a result is due.
  always @(negedge clk) begin
    checkOutput("in_ready", longint'(bus.in_ready), longint'(expReady));
    checkOutput("out_valid", longint'(bus.out_valid), longint'(expValid));
    if (expValid) begin
      checkOutput("out_sum", longint'(bus.out_sum), longint'(expSum));
      checkOutput("out_count", longint'(bus.out_count), longint'(expCount));
    end
  end

  task automatic modelClear();
    modelAcc = 0;
    modelCnt = 0;
    expReady = 1'b1;
    expValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                               input logic [1:0] en, input logic last);
    logic closing;
    closing          = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_data      = {d1, d0};
    bus.in_lane_en   = en;
    bus.in_last      = last;
    @(posedge clk);
    if (expReady) begin
      if (en[0]) modelAcc += extendOp(d0);
      if (en[1]) modelAcc += extendOp(d1);
      modelCnt += longint'($countones(en));
      closing = last;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (closing) begin
      expReady = 1'b0;
      checkOutput("resolve-cycle out_valid", longint'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      expValid = 1'b1;
      expSum   = OUT_W'(modelAcc);
      expCount = (modelCnt > 65535) ? 16'hFFFF : 16'(modelCnt);
    end
  endtask

  // Checks the presented result against literals, holds it, then hands it off.
  task automatic takeResult(input string name, input longint litSum, input longint litCount,
                            input int holdCycles);
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput({name, " valid"}, longint'(bus.out_valid), 1);
    checkOutput({name, " model sum"}, longint'(expSum), litSum);
    checkOutput({name, " sum"}, longint'(bus.out_sum), litSum);
    checkOutput({name, " count"}, longint'(bus.out_count), litCount);
    for (int i = 0; i < holdCycles; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_data    = {8'd50, 8'd50};
      bus.in_lane_en = 2'b11;
      bus.in_last    = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({name, " held sum"}, longint'(bus.out_sum), litSum);
      checkOutput({name, " held in_ready"}, longint'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    modelClear();
  endtask

  task automatic applyReset(input int cycles);
    rst_n = 1'b0;
    modelClear();
    #1;
    checkOutput("reset in_ready", longint'(bus.in_ready), 1);
    checkOutput("reset out_valid", longint'(bus.out_valid), 0);
    checkOutput("reset out_sum", longint'(bus.out_sum), 0);
    checkOutput("reset out_count", longint'(bus.out_count), 0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_lane_en = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    expSum         = '0;
    expCount       = '0;
    modelClear();
    applyReset(2);

    // Ten mixed operands across five beats.
    applyStimulus(8'd11, 8'd2, 2'b11, 1'b0);
    applyStimulus(8'd13, 8'd4, 2'b11, 1'b0);
    applyStimulus(8'd5, 8'd6, 2'b11, 1'b0);
    applyStimulus(8'd7, 8'd8, 2'b11, 1'b0);
    applyStimulus(8'd9, 8'd10, 2'b11, 1'b1);
    takeResult("ten operands", 75, 10, 0);

    for (int i = 0; i < 4; i++) applyStimulus(8'd255, 8'd255, 2'b11, 1'b0);
    applyStimulus(8'd255, 8'd254, 2'b11, 1'b1);
`ifdef CSA_SIGNED_EN
    takeResult("all ones", 262133, 10, 0);
`else
    takeResult("all ones", 2549, 10, 0);
`endif

    // Single beat with lane 1 masked; result then held with junk input offered.
    applyStimulus(8'd200, 8'd77, 2'b01, 1'b1);
`ifdef CSA_SIGNED_EN
    takeResult("lane mask", 262088, 1, 5);
`else
    takeResult("lane mask", 200, 1, 5);
`endif
    applyStimulus(8'd3, 8'd14, 2'b11, 1'b1);
    takeResult("after hold", 17, 2, 0);

    // Reset mid-transaction discards the partial sum.
    applyStimulus(8'd1, 8'd2, 2'b11, 1'b0);
    applyStimulus(8'd3, 8'd4, 2'b11, 1'b0);
    applyReset(2);
    applyStimulus(8'd1, 8'd1, 2'b11, 1'b1);
    takeResult("after reset", 2, 2, 0);

    // Reset while a result is presented.
    applyStimulus(8'd5, 8'd5, 2'b11, 1'b1);
    applyReset(1);
    applyStimulus(8'hFF, 8'h03, 2'b11, 1'b1);
`ifdef CSA_SIGNED_EN
    takeResult("ff plus 3", 2, 2, 0);
`else
    takeResult("ff plus 3", 258, 2, 0);
`endif

    // Empty beats contribute nothing but may still close a transaction.
    applyStimulus(8'd9, 8'd9, 2'b00, 1'b1);
    takeResult("empty last", 0, 0, 0);
    applyStimulus(8'd9, 8'd9, 2'b00, 1'b0);
    applyStimulus(8'd1, 8'd0, 2'b01, 1'b1);
    takeResult("empty then one", 1, 1, 0);

    // Accumulator wraps modulo 2^OUT_W.
    for (int i = 0; i < 519; i++) applyStimulus(8'd255, 8'd255, 2'b11, 1'b0);
    applyStimulus(8'd255, 8'd255, 2'b11, 1'b1);
`ifdef CSA_SIGNED_EN
    takeResult("wrap", 261104, 1040, 0);
`else
    takeResult("wrap", 3056, 1040, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
